bus_bank_decoder: RTL and testbench

Parametrised bank decoder and response arbiter between the CPU bus master and up to `NSLAVES` bank slaves (RAM, LED port, video, …). It decodes the bank field of the address, forwards a registered strobe to exactly one slave, returns that slave's ack and read data, and answers unmapped or stalled accesses with an error response. It replaces hand-written per-bank `case` decoding and ack muxing at the top level.

---
 rtl/bus_bank_decoder_pkg.sv | 17 +
 rtl/bus_bank_decoder_if.sv | 37 +++
 rtl/bus_bank_decoder_timeout.sv | 31 +++
 rtl/bus_bank_decoder.sv | 163 ++++++++++++++++
 tb/tb_bus_bank_decoder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_bank_decoder_pkg.sv
// Shared types and constants for the bus bank decoder slice.
package bus_bank_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADR_W  = 32;
  localparam int unsigned SEL_W  = 4;

  // Read data returned with every error response.
  localparam logic [DATA_W-1:0] ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/bus_bank_decoder_if.sv
// Bus bundle between the CPU master, the bank decoder and the bank slaves.
// The slave modport is the decoder's view; master is the environment's view.
interface bus_bank_decoder_if #(
  parameter int unsigned NSLAVES = 4
);
  import bus_bank_pkg::*;

  // CPU master side
  logic                      m_stb_i;
  logic                      m_we_i;
  logic [ADR_W-1:0]          m_adr_i;
  logic [DATA_W-1:0]         m_dat_i;
  logic [SEL_W-1:0]          m_sel_i;
  logic                      m_ack_o;
  logic                      m_err_o;
  logic [DATA_W-1:0]         m_dat_o;

  // Bank slave side
  logic [NSLAVES-1:0]        s_stb_o;
  logic                      s_we_o;
  logic [ADR_W-1:0]          s_adr_o;
  logic [DATA_W-1:0]         s_dat_o;
  logic [SEL_W-1:0]          s_sel_o;
  logic [NSLAVES-1:0]        s_ack_i;
  logic [DATA_W*NSLAVES-1:0] s_dat_i;

  modport slave (
    input  m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

endinterface

// File: rtl/bus_bank_decoder_timeout.sv
// Stall timer for the bank decoder. Present only when
// BUS_BANK_DECODER_TIMEOUT_EN is defined.
// Loads TIMEOUT-1 on clr, counts down while en, flags expiry at zero.
`ifdef BUS_BANK_DECODER_TIMEOUT_EN
module bus_bank_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [15:0] r_cnt;

  // Down-counter, saturating at zero.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= 16'(TIMEOUT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule
`endif

// File: rtl/bus_bank_decoder.sv
// Bank decoder and response arbiter: routes one master access to the slave
// selected by the address bank field and returns its ack/data, or an error
// for unmapped banks. Stall timeout is enabled by BUS_BANK_DECODER_TIMEOUT_EN.
module bus_bank_decoder
  import bus_bank_pkg::*;
#(
  parameter int unsigned NSLAVES   = 4,
  parameter int unsigned BANK_MSB  = 31,
  parameter int unsigned BANK_LSB  = 24,
  parameter int unsigned BANK_BASE = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_ni,
  bus_bank_decoder_if.slave   bus,
  output logic [ADR_W-1:0]    err_adr_o
);

  localparam int unsigned BW = BANK_MSB - BANK_LSB + 1;

  if ((NSLAVES < 1) || (NSLAVES > 16)) begin : g_bad_nslaves
    $error("bus_bank_decoder: NSLAVES must be 1..16");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("bus_bank_decoder: TIMEOUT must be 1..65535");
  end

  state_e              r_state;
  logic [NSLAVES-1:0]  r_stb;
  logic                r_we;
  logic [ADR_W-1:0]    r_adr;
  logic [DATA_W-1:0]   r_wdat;
  logic [SEL_W-1:0]    r_sel;
  logic                r_ack;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdat;
  logic [ADR_W-1:0]    r_err_adr;
  logic [3:0]          r_idx;

  logic [BW-1:0]       w_bank;
  logic [BW-1:0]       w_idx;
  logic [31:0]         w_idx32;
  logic                w_mapped;
  logic                w_ack_sel;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_expired;

  assign w_bank   = bus.m_adr_i[BANK_MSB:BANK_LSB];
  // Wraps in bank-field width, so banks below BANK_BASE land out of range.
  assign w_idx    = w_bank - BW'(BANK_BASE);
  assign w_idx32  = 32'(w_idx);
  assign w_mapped = (w_idx32 < NSLAVES);

`ifdef BUS_BANK_DECODER_TIMEOUT_EN
  logic w_cnt_clr;
  logic w_cnt_en;

  assign w_cnt_clr = (r_state == ST_IDLE) && bus.m_stb_i && w_mapped;
  assign w_cnt_en  = (r_state == ST_ACTIVE);

  bus_bank_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Pick ack and read data of the selected channel only.
  always_comb begin
    w_ack_sel = 1'b0;
    w_rdata   = '0;
    for (int unsigned k = 0; k < NSLAVES; k++) begin
      if (r_idx == 4'(k)) begin
        w_ack_sel = bus.s_ack_i[k];
        w_rdata   = bus.s_dat_i[DATA_W*k +: DATA_W];
      end
    end
  end

  // Request/response FSM with registered master and slave outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_stb     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_sel     <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdat    <= '0;
      r_err_adr <= '0;
      r_idx     <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.m_stb_i) begin
            r_we   <= bus.m_we_i;
            r_adr  <= bus.m_adr_i;
            r_wdat <= bus.m_dat_i;
            r_sel  <= bus.m_sel_i;
            if (w_mapped) begin
              r_idx   <= w_idx32[3:0];
              r_stb   <= NSLAVES'(1) << w_idx32[3:0];
              r_state <= ST_ACTIVE;
            end else begin
              r_ack     <= 1'b1;
              r_err     <= 1'b1;
              r_rdat    <= ERR_DATA;
              r_err_adr <= bus.m_adr_i;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_ACTIVE: begin
          // Abort takes precedence: a master that dropped strobe expects no response.
          if (!bus.m_stb_i) begin
            r_stb   <= '0;
            r_state <= ST_IDLE;
          end else if (w_ack_sel) begin
            r_ack   <= 1'b1;
            r_rdat  <= r_we ? '0 : w_rdata;
            r_stb   <= '0;
            r_state <= ST_RESP;
          end else if (w_expired) begin
            r_ack     <= 1'b1;
            r_err     <= 1'b1;
            r_rdat    <= ERR_DATA;
            r_err_adr <= r_adr;
            r_stb     <= '0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_stb   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_ack_o = r_ack;
  assign bus.m_err_o = r_err;
  assign bus.m_dat_o = r_rdat;
  assign bus.s_stb_o = r_stb;
  assign bus.s_we_o  = r_we;
  assign bus.s_adr_o = r_adr;
  assign bus.s_dat_o = r_wdat;
  assign bus.s_sel_o = r_sel;
  assign err_adr_o   = r_err_adr;

endmodule

// File: tb/tb_bus_bank_decoder.sv
// Scoreboard bench for bus_bank_decoder: stimulus queues expected responses,
// a monitor pops and compares on every m_ack_o. Timeout cases are exercised
// when BUS_BANK_DECODER_TIMEOUT_EN is defined.
module tb_bus_bank_decoder;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic [31:0] eadr;
  } exp_t;

  logic        clk;
  logic        rst_ni;
  logic [31:0] err_adr;

  bus_bank_decoder_if #(.NSLAVES(4)) bus ();

  bus_bank_decoder #(
    .NSLAVES   (4),
    .BANK_MSB  (31),
    .BANK_LSB  (24),
    .BANK_BASE (0),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .err_adr_o (err_adr)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [31:0] model_eadr = 32'h0;

  int          ws[4];
  int          cnt[4];
  logic [3:0]  resp_ack = 4'b0;
  logic [3:0]  force_ack = 4'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.s_ack_i = resp_ack | force_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Slave model: channel k acks after ws[k] strobe cycles (negative = never).
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.s_stb_o[k]) begin
        resp_ack[k] = (ws[k] >= 0) && (cnt[k] == ws[k]);
        cnt[k]++;
      end else begin
        resp_ack[k] = 1'b0;
        cnt[k] = 0;
      end
    end
  end

  // Monitor: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni && bus.m_ack_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 expected=0 dat=%h err=%b", bus.m_dat_o, bus.m_err_o);
      end else begin
        e = q.pop_front();
        chk("m_err_o", 32'(bus.m_err_o), 32'(e.err));
        chk("m_dat_o", bus.m_dat_o, e.dat);
        chk("err_adr_o", err_adr, e.eadr);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_ack"}, 32'(bus.m_ack_o), 32'h0);
    chk({tag, "_m_err"}, 32'(bus.m_err_o), 32'h0);
    chk({tag, "_m_dat"}, bus.m_dat_o, 32'h0);
    chk({tag, "_s_stb"}, 32'(bus.s_stb_o), 32'h0);
    chk({tag, "_s_we"}, 32'(bus.s_we_o), 32'h0);
    chk({tag, "_s_adr"}, bus.s_adr_o, 32'h0);
    chk({tag, "_s_dat"}, bus.s_dat_o, 32'h0);
    chk({tag, "_s_sel"}, 32'(bus.s_sel_o), 32'h0);
    chk({tag, "_err_adr"}, err_adr, 32'h0);
  endtask

  // One complete access: queue expectation, drive, check latency and strobes.
  task automatic do_req(input string name, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_dat, input logic [3:0] exp_stb);
    int   lat;
    logic got;
    exp_t e;
    if (exp_err) model_eadr = adr;
    e.err  = exp_err;
    e.dat  = exp_dat;
    e.eadr = model_eadr;
    q.push_back(e);
    @(negedge clk);
    bus.m_stb_i = 1'b1;
    bus.m_we_i  = we;
    bus.m_adr_i = adr;
    bus.m_dat_i = dat;
    bus.m_sel_i = sel;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk({name, "_s_stb"}, 32'(bus.s_stb_o), 32'(exp_stb));
        chk({name, "_s_adr"}, bus.s_adr_o, adr);
        chk({name, "_s_dat"}, bus.s_dat_o, dat);
        chk({name, "_s_sel_we"}, {27'h0, bus.s_we_o, bus.s_sel_o}, {27'h0, we, sel});
      end
      if (bus.m_ack_o) got = 1'b1;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_s_stb_cleared"}, 32'(bus.s_stb_o), 32'h0);
    bus.m_stb_i = 1'b0;
    @(negedge clk);
    chk({name, "_ack_one_cycle"}, 32'(bus.m_ack_o), 32'h0);
  endtask

  initial begin
    int acks;
    rst_ni          = 1'b0;
    bus.m_stb_i     = 1'b0;
    bus.m_we_i      = 1'b0;
    bus.m_adr_i     = '0;
    bus.m_dat_i     = '0;
    bus.m_sel_i     = '0;
    bus.s_dat_i     = {32'hDEAD0003, 32'h22220002, 32'h11110001, 32'hCAFE0001};
    for (int k = 0; k < 4; k++) begin
      ws[k]  = -1;
      cnt[k] = 0;
    end

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    // Zero-wait read of bank 0.
    ws[0] = 0;
    do_req("rd_bank0", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 2, 1'b0, 32'hCAFE0001, 4'b0001);

    // Write to bank 1 returns zero data.
    ws[1] = 1;
    do_req("wr_bank1", 1'b1, 32'h0100_0000, 32'h0000_005A, 4'b0001, 3, 1'b0, 32'h0, 4'b0010);

    // Unmapped bank 7.
    do_req("unmapped", 1'b0, 32'h0700_0004, 32'h0, 4'hF, 1, 1'b1, 32'h0, 4'b0000);

    // Read of bank 3 with two wait states.
    ws[3] = 2;
    do_req("rd_bank3", 1'b0, 32'h0300_0008, 32'h0, 4'hF, 4, 1'b0, 32'hDEAD0003, 4'b1000);

    // Ack on channel 3 while channel 1 is selected must be ignored.
    ws[1]     = 3;
    force_ack = 4'b1000;
    do_req("foreign_ack", 1'b0, 32'h0100_0004, 32'h0, 4'hF, 5, 1'b0, 32'h11110001, 4'b0010);
    force_ack = 4'b0000;

`ifdef BUS_BANK_DECODER_TIMEOUT_EN
    // Slave 2 never acks: error after TIMEOUT+1 cycles.
    ws[2] = -1;
    do_req("timeout", 1'b0, 32'h0200_0000, 32'h0, 4'hF, 9, 1'b1, 32'h0, 4'b0100);
    // Ack sampled on the expiry edge wins over the timeout.
    ws[2] = 7;
    do_req("ack_at_expiry", 1'b0, 32'h0200_0010, 32'h0, 4'hF, 9, 1'b0, 32'h22220002, 4'b0100);
`endif

    // Master abort in ACTIVE: strobe cleared, no response.
    ws[2] = -1;
    @(negedge clk);
    bus.m_stb_i = 1'b1;
    bus.m_we_i  = 1'b0;
    bus.m_adr_i = 32'h0200_0040;
    repeat (3) @(negedge clk);
    chk("abort_s_stb_active", 32'(bus.s_stb_o), 32'h4);
    bus.m_stb_i = 1'b0;
    acks = 0;
    @(negedge clk);
    chk("abort_s_stb_cleared", 32'(bus.s_stb_o), 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (bus.m_ack_o) acks++;
      @(negedge clk);
    end
    chk("abort_no_ack", 32'(acks), 32'h0);

    // Reset asserted mid-access clears everything at once.
    ws[1] = -1;
    @(negedge clk);
    bus.m_stb_i = 1'b1;
    bus.m_adr_i = 32'h0100_0020;
    repeat (2) @(negedge clk);
    chk("rst_pre_s_stb", 32'(bus.s_stb_o), 32'h2);
    #2 rst_ni = 1'b0;
    #1;
    model_eadr  = 32'h0;
    chk_all_zero("rst_active");
    bus.m_stb_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    ws[0] = 0;
    do_req("post_reset", 1'b0, 32'h0000_0020, 32'h0, 4'hF, 2, 1'b0, 32'hCAFE0001, 4'b0001);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
